// File: rtl/ex_div_unit.sv
// Iterative restoring radix-2 divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Holds the pipeline through stall_req_o while a division is in flight; result_valid_o pulses once.
module ex_div_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_valid_i,
    input  logic [1:0]      div_op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic             word_q;
    logic             qneg_q;
    logic             rneg_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  result_q;

    logic             is_signed;
    logic [XLEN-1:0]  opa, opb, abs_a, abs_b;
    logic             sa, sb, div0, ovf;
    logic [XLEN:0]    shl_d, sub_d;
    logic             ge_d;
    logic [XLEN-1:0]  rem_d, quo_d;

    // Apply signs, pick quotient or remainder, and sign-extend W results.
    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                            input logic qn, input logic rn,
                                            input logic sel_r, input logic w);
        logic [XLEN-1:0] v;
        v = sel_r ? (rn ? -r : r) : (qn ? -q : q);
        if (w) v = {{(XLEN-32){v[31]}}, v[31:0]};
        return v;
    endfunction

    always_comb begin
        is_signed = ~div_op_i[0];
        if (word_i) begin
            opa = {{(XLEN-32){is_signed & src1_i[31]}}, src1_i[31:0]};
            opb = {{(XLEN-32){is_signed & src2_i[31]}}, src2_i[31:0]};
        end else begin
            opa = src1_i;
            opb = src2_i;
        end
        sa    = is_signed & opa[XLEN-1];
        sb    = is_signed & opb[XLEN-1];
        abs_a = sa ? -opa : opa;
        abs_b = sb ? -opb : opb;
        div0  = (opb == '0);
        ovf   = is_signed & (opa == (word_i ? MIN_W : MIN_D)) & (opb == '1);
    end

    // One restoring step: bring in the next dividend bit, subtract when it fits.
    always_comb begin
        shl_d = {rem_q, quo_q[XLEN-1]};
        sub_d = shl_d - {1'b0, dvs_q};
        ge_d  = ~sub_d[XLEN];
        rem_d = ge_d ? sub_d[XLEN-1:0] : shl_d[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ge_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_valid_i) begin
                        op_q   <= div_op_i;
                        word_q <= word_i;
                        qneg_q <= sa ^ sb;
                        rneg_q <= sa;
                        dvs_q  <= abs_b;
                        rem_q  <= '0;
                        // W dividends are parked in the top half so the MSB-first shift works unchanged.
                        quo_q  <= word_i ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
                        cnt_q  <= word_i ? CNT_W'(31) : CNT_W'(XLEN-1);
                        if (div0) begin
                            state_q  <= DONE;
                            result_q <= fmt('1, opa, 1'b0, 1'b0, div_op_i[1], word_i);
                        end else if (ovf) begin
                            state_q  <= DONE;
                            result_q <= fmt(opa, '0, 1'b0, 1'b0, div_op_i[1], word_i);
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        state_q  <= DONE;
                        result_q <= fmt(quo_d, rem_d, qneg_q, rneg_q, op_q[1], word_q);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign result_valid_o = (state_q == DONE) & ~flush_i;
    assign stall_req_o    = ~flush_i & (((state_q == IDLE) & div_valid_i) | (state_q == CALC));
    assign result_o       = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: driver pushes model results, a monitor pops them on each result pulse.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_valid_i;
    logic [1:0]  div_op_i;
    logic        word_i;
    logic [63:0] src1_i;
    logic [63:0] src2_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        busy_o;
    logic        result_valid_o;
    logic [63:0] result_o;

    ex_div_unit #(.XLEN(64), .CNT_W(7)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .div_valid_i    (div_valid_i),
        .div_op_i       (div_op_i),
        .word_i         (word_i),
        .src1_i         (src1_i),
        .src2_i         (src2_i),
        .flush_i        (flush_i),
        .stall_req_o    (stall_req_o),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] val;
        int          due;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension division semantics with plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b,
                                          output bit special);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              sa32, sb32;
        int unsigned     ua32, ub32;
        logic [63:0]     q, r;
        logic [31:0]     q32, r32, v32;
        bit              sgn;
        sgn     = !op[0];
        special = 1'b0;
        if (w) begin
            sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
            if (ub32 == 0) begin
                special = 1'b1; q32 = '1; r32 = a[31:0];
            end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                special = 1'b1; q32 = a[31:0]; r32 = '0;
            end else if (sgn) begin
                q32 = sa32 / sb32; r32 = sa32 % sb32;
            end else begin
                q32 = ua32 / ub32; r32 = ua32 % ub32;
            end
            v32 = op[1] ? r32 : q32;
            return {{32{v32[31]}}, v32};
        end
        sa = a; sb = b; ua = a; ub = b;
        if (ub == 0) begin
            special = 1'b1; q = '1; r = a;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            special = 1'b1; q = a; r = '0;
        end else if (sgn) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = ua / ub; r = ua % ub;
        end
        return op[1] ? r : q;
    endfunction

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'h0000_0000_8000_0000;
            4, 5:    v = {$urandom, $urandom};
            6:       v = 64'($urandom_range(0, 1000));
            default: v = -64'($urandom_range(1, 1000));
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && result_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pulse: result_valid_o=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_val"}, result_o, e.val);
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
                check({e.name, "_stall_done"}, 64'(stall_req_o), 64'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input string nm);
        bit          sp, got, stall_ok;
        logic [63:0] e;
        int          t0, lat;
        @(posedge clk); #1;
        div_valid_i = 1'b1; div_op_i = op; word_i = w; src1_i = a; src2_i = b;
        t0  = cyc;
        e   = model(op, w, a, b, sp);
        lat = sp ? 1 : (w ? 33 : 65);
        sb_q.push_back('{e, t0 + lat, nm});
        #1 check({nm, "_stall_acc"}, 64'(stall_req_o), 64'd1);
        got = 1'b0; stall_ok = 1'b1;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (result_valid_o) got = 1'b1;
            else if (!stall_req_o) stall_ok = 1'b0;
        end
        check({nm, "_done_seen"}, 64'(got), 64'd1);
        check({nm, "_stall_busy"}, 64'(stall_ok), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; div_valid_i = 1'b0; div_op_i = '0; word_i = 1'b0;
        src1_i = '0; src2_i = '0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(result_valid_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_stall", 64'(stall_req_o), 64'd0);
        rst_n = 1'b1;

        issue(2'b01, 1'b0, 64'd100, 64'd7, "divu_100_7");
        issue(2'b11, 1'b0, 64'd100, 64'd7, "remu_100_7");
        issue(2'b00, 1'b0, -64'd20, 64'd3, "div_m20_3");
        issue(2'b10, 1'b0, -64'd20, 64'd3, "rem_m20_3");
        issue(2'b10, 1'b0, 64'd20, -64'd3, "rem_20_m3");
        issue(2'b00, 1'b0, 64'd5, 64'd0, "div_5_0");
        issue(2'b11, 1'b0, 64'd5, 64'd0, "remu_5_0");
        issue(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, "div_ovf");
        issue(2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, "rem_ovf");
        issue(2'b00, 1'b1, 64'h1_8000_0000, 64'd2, "divw");
        issue(2'b01, 1'b1, 64'h1_8000_0000, 64'd2, "divuw");
        issue(2'b10, 1'b1, 64'h0000_0000_8000_0000, '1, "remw_ovf");

        // Flush ten cycles into a long DIV; no result may appear.
        @(posedge clk); #1;
        div_valid_i = 1'b1; div_op_i = 2'b00; word_i = 1'b0;
        src1_i = 64'h1234_5678_9ABC_DEF0; src2_i = 64'd77;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1; div_valid_i = 1'b0;
        #1 check("flush_stall", 64'(stall_req_o), 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        repeat (3) @(posedge clk);
        issue(2'b01, 1'b0, 64'd9, 64'd3, "divu_after_flush");

        // Asynchronous reset in the middle of a calculation.
        @(posedge clk); #1;
        div_valid_i = 1'b1; div_op_i = 2'b01; src1_i = 64'd1000; src2_i = 64'd3;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0; div_valid_i = 1'b0;
        #1;
        check("midreset_busy", 64'(busy_o), 64'd0);
        check("midreset_result", result_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(2'b11, 1'b0, 64'd1000, 64'd3, "remu_after_reset");

        for (int k = 0; k < 40; k++) begin
            issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  rnd_operand(), rnd_operand(), $sformatf("rnd%0d", k));
        end

        @(posedge clk); #1;
        div_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("end_busy", 64'(busy_o), 64'd0);
        check("end_queue_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
